module_divisor_seq: RTL and testbench

- Parametrised sequential restoring divider: unsigned N-bit dividend / N-bit divisor, one quotient bit per clock.
- Each iteration is the (N+1)-bit partial-remainder minus divisor step with a sign flag, generalised from the fixed 5-bit/4-bit subtractor stage and iterated under an FSM.
- Sits between the operand-capture logic and the result display path.
- Start/busy/done handshake; results are registered and held.

---
 rtl/module_divisor_seq.sv | 123 ++++++++++++
 tb/tb_module_divisor_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/module_divisor_seq.sv
// Sequential restoring divider: unsigned N-bit dividend / N-bit divisor, one quotient bit per clock.
// A start/busy/done handshake; quotient, remainder and divide-by-zero flag are registered and held.
module module_divisor_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         div_cero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state_reg, state_next;
    logic [N:0]    r_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  cociente_reg;
    logic [N-1:0]  residuo_reg;
    logic          div_cero_reg;

    logic          accept;
    logic          last_step;
    logic [N:0]    r_shift;
    logic [N:0]    diff;
    logic          signo;
    logic [N:0]    r_step;
    logic [N-1:0]  q_step;

    // start is only honoured in IDLE, or in FIN for a back-to-back accept
    assign accept    = start && (state_reg == IDLE || state_reg == FIN);
    assign last_step = (state_reg == CALC) && (cnt_reg == CW'(1));

    // One restoring step; N+1 bits wide so the subtraction cannot overflow
    assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
    assign diff    = r_shift - {1'b0, b_reg};
    assign signo   = diff[N];
    assign r_step  = signo ? r_shift : diff;
    assign q_step  = {q_reg[N-2:0], ~signo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIN : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == CALC);
        done = (state_reg == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg        <= '0;
            q_reg        <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            cociente_reg <= '0;
            residuo_reg  <= '0;
            div_cero_reg <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                r_reg   <= '0;
                q_reg   <= dividendo;
                b_reg   <= divisor;
                cnt_reg <= CW'(N);
            end else begin
                // Divide by zero finishes immediately with a saturated quotient
                cociente_reg <= '1;
                residuo_reg  <= dividendo;
                div_cero_reg <= 1'b1;
            end
        end else if (state_reg == CALC) begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg - CW'(1);
            if (last_step) begin
                cociente_reg <= q_step;
                residuo_reg  <= r_step[N-1:0];
                div_cero_reg <= 1'b0;
            end
        end
    end

    assign cociente = cociente_reg;
    assign residuo  = residuo_reg;
    assign div_cero = div_cero_reg;

endmodule

// File: tb/tb_module_divisor_seq.sv
// Directed and table-driven checks of module_divisor_seq at N=4 and N=8,
// including latency, divide-by-zero, back-to-back accepts and mid-operation reset.
module tb_module_divisor_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] dvd4 = '0, dvs4 = '0;
    logic       busy4, done4, dz4;
    logic [3:0] coc4, res4;

    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] coc8, res8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    module_divisor_seq #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividendo(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .cociente(coc4), .residuo(res4), .div_cero(dz4)
    );

    module_divisor_seq #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividendo(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .cociente(coc8), .residuo(res8), .div_cero(dz8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then count busy cycles and the cycle in which done appears
    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int bz);
        @(negedge clk);
        start4 = 1'b1; dvd4 = a; dvs4 = b;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0; bz = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy4) bz++;
            if (done4) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bz);
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; bz = 0;
        for (int c = 1; c <= 60; c++) begin
            if (busy8) bz++;
            if (done8) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, bz;
        logic [3:0] eq, er;
        logic [3:0] sa[7];
        logic [3:0] sb[7];
        int acc;

        tv[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1,  z: 1'b0};
        tv[1] = '{a: 4'd9,  b: 4'd9,  q: 4'd1,  r: 4'd0,  z: 1'b0};
        tv[2] = '{a: 4'd7,  b: 4'd12, q: 4'd0,  r: 4'd7,  z: 1'b0};
        tv[3] = '{a: 4'd15, b: 4'd0,  q: 4'd15, r: 4'd15, z: 1'b1};
        tv[4] = '{a: 4'd6,  b: 4'd4,  q: 4'd1,  r: 4'd2,  z: 1'b0};
        tv[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0,  z: 1'b0};
        tv[6] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  z: 1'b0};
        tv[7] = '{a: 4'd8,  b: 4'd0,  q: 4'd15, r: 4'd8,  z: 1'b1};
        tv[8] = '{a: 4'd14, b: 4'd7,  q: 4'd2,  r: 4'd0,  z: 1'b0};

        // Reset state
        #2;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_out",  {coc4, res4, dz4}, 0);
        check("rst_out8", {coc8, res8, dz8}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single divisions
        for (int i = 0; i < 9; i++) begin
            run4(tv[i].a, tv[i].b, lat, bz);
            $display("div %0d/%0d -> q=%0d r=%0d z=%0d lat=%0d busy=%0d",
                     tv[i].a, tv[i].b, coc4, res4, dz4, lat, bz);
            check("tv_q",   coc4, tv[i].q);
            check("tv_r",   res4, tv[i].r);
            check("tv_z",   dz4,  tv[i].z);
            check("tv_lat", lat,  tv[i].z ? 1 : 5);
            check("tv_bz",  bz,   tv[i].z ? 0 : 4);
            @(negedge clk);
            check("tv_pulse", done4, 0);
        end

        // N=8 boundary case
        run8(8'd255, 8'd16, lat, bz);
        $display("div8 255/16 -> q=%0d r=%0d z=%0d lat=%0d busy=%0d", coc8, res8, dz8, lat, bz);
        check("n8_q",   coc8, 15);
        check("n8_r",   res8, 15);
        check("n8_z",   dz8,  0);
        check("n8_lat", lat,  9);
        check("n8_bz",  bz,   8);

        // Exhaustive N=4 sweep against the arithmetic definition
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b), lat, bz);
                if (b == 0) begin
                    eq = 4'd15; er = 4'(a);
                end else begin
                    eq = 4'(a / b); er = 4'(a % b);
                end
                $display("sweep %0d/%0d -> q=%0d r=%0d z=%0d", a, b, coc4, res4, dz4);
                check("sweep", {coc4, res4, dz4, 8'(lat)},
                      {eq, er, (b == 0), 8'((b == 0) ? 1 : 5)});
                if (b != 0)
                    check("invariant", (int'(coc4) * b + int'(res4) == a) && (int'(res4) < b), 1);
            end
        end

        // start held high with operands changing every cycle
        sa = '{4'd13, 4'd9, 4'd7, 4'd14, 4'd15, 4'd11, 4'd10};
        sb = '{4'd3,  4'd9, 4'd12, 4'd5, 4'd2,  4'd4,  4'd3};
        @(negedge clk);
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) begin
                if (j % 5 == 0) begin
                    acc = (j - 5) % 7;
                    $display("b2b j=%0d %0d/%0d -> q=%0d r=%0d done=%0d",
                             j, sa[acc], sb[acc], coc4, res4, done4);
                    check("b2b_done", done4, 1);
                    check("b2b_res", {coc4, res4, dz4},
                          {4'(sa[acc] / sb[acc]), 4'(sa[acc] % sb[acc]), 1'b0});
                end else begin
                    check("b2b_idle", {done4, busy4}, 2'b01);
                end
            end
            start4 = 1'b1;
            dvd4 = sa[j % 7];
            dvs4 = sb[j % 7];
            @(negedge clk);
        end
        start4 = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);

        // Mid-operation asynchronous reset after a divide-by-zero left nonzero outputs
        run4(4'd15, 4'd0, lat, bz);
        @(negedge clk);
        start4 = 1'b1; dvd4 = 4'd13; dvs4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy4, 1);
        check("rst_mid_held", {coc4, res4, dz4}, {4'd15, 4'd15, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        $display("reset mid-op -> q=%0d r=%0d z=%0d busy=%0d done=%0d", coc4, res4, dz4, busy4, done4);
        check("rst_mid_out", {coc4, res4, dz4, busy4, done4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done4 || busy4) acc++;
        end
        check("rst_no_done", acc, 0);
        run4(4'd6, 4'd4, lat, bz);
        $display("after reset 6/4 -> q=%0d r=%0d z=%0d lat=%0d", coc4, res4, dz4, lat);
        check("post_rst", {coc4, res4, dz4, 8'(lat)}, {4'd1, 4'd2, 1'b0, 8'd5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
